// File: rtl/rr_range_arbiter.sv
// Round-robin arbiter restricted to the requester window [range_lo, range_hi], holding a one-hot grant until release.
// Optional grant timeout is compiled in with `define ARB_TIMEOUT_EN.
module rr_range_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] range_lo,
  input  logic [$clog2(N)-1:0] range_hi,
  input  logic                 done,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 grant_valid,
`ifdef ARB_TIMEOUT_EN
  output logic                 timeout_pulse,
`endif
  output logic                 state_o
);

  localparam int IW = $clog2(N);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e          state_q;
  logic [N-1:0]    grant_q;
  logic [IW-1:0]   grant_id_q;
  logic            grant_valid_q;
  logic [IW-1:0]   ptr_q;

  logic            found;
  logic [IW-1:0]   win;
  logic [IW-1:0]   start;
  logic [IW:0]     span;
  logic [IW:0]     cand;
  logic            release_c;
  logic            force_off;

  // Handshake: req is level-held by a requester; the owner ends its tenure with a
  // one-cycle done pulse or by dropping req. done outside BUSY has no effect.
  assign release_c = done || !req[grant_id_q];
  assign start     = (ptr_q >= range_lo && ptr_q <= range_hi) ? ptr_q : range_lo;

  // Walk the window from start, folding indices past range_hi back to range_lo.
  always_comb begin
    found = 1'b0;
    win   = '0;
    span  = '0;
    cand  = '0;
    if (range_lo <= range_hi) begin
      span = {1'b0, range_hi} - {1'b0, range_lo} + (IW+1)'(1);
      for (int k = 0; k < N; k++) begin
        cand = {1'b0, start} + (IW+1)'(k);
        if (cand > {1'b0, range_hi}) cand = cand - span;
        if (!found && ((IW+1)'(k) < span) && req[cand[IW-1:0]]) begin
          found = 1'b1;
          win   = cand[IW-1:0];
        end
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_q;
  logic          timeout_pulse_q;

  assign force_off = (state_q == BUSY) && !release_c && (hold_q == HW'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q          <= '0;
      timeout_pulse_q <= 1'b0;
    end else begin
      timeout_pulse_q <= force_off;
      if (state_q == IDLE) hold_q <= '0;
      else                 hold_q <= hold_q + HW'(1);
    end
  end

  assign timeout_pulse = timeout_pulse_q;
`else
  logic unused_max_hold;
  assign unused_max_hold = ^MAX_HOLD;
  assign force_off       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      ptr_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            state_q       <= BUSY;
            grant_q       <= {{(N-1){1'b0}}, 1'b1} << win;
            grant_id_q    <= win;
            grant_valid_q <= 1'b1;
            ptr_q         <= (win == range_hi) ? range_lo : win + IW'(1);
          end
        end
        BUSY: begin
          if (release_c || force_off) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = grant_valid_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_rr_range_arbiter.sv
// Directed bench for rr_range_arbiter (N=4, MAX_HOLD=4); expected values are hand-derived per step.
module tb_rr_range_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [1:0] range_lo;
  logic [1:0] range_hi;
  logic       done;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       grant_valid;
  logic       state_o;
`ifdef ARB_TIMEOUT_EN
  logic       timeout_pulse;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rr_range_arbiter #(.N(4), .MAX_HOLD(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .range_lo    (range_lo),
    .range_hi    (range_hi),
    .done        (done),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
`ifdef ARB_TIMEOUT_EN
    .timeout_pulse (timeout_pulse),
`endif
    .state_o     (state_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] eg, input logic [1:0] eid,
                       input logic ev, input logic chk_id);
    tests++;
    assert (grant === eg) else begin
      fails++;
      $error("FAIL %s grant got %b exp %b", tag, grant, eg);
    end
    tests++;
    assert (grant_valid === ev) else begin
      fails++;
      $error("FAIL %s grant_valid got %b exp %b", tag, grant_valid, ev);
    end
    tests++;
    assert (state_o === ev) else begin
      fails++;
      $error("FAIL %s state got %b exp %b", tag, state_o, ev);
    end
    if (chk_id) begin
      tests++;
      assert (grant_id === eid) else begin
        fails++;
        $error("FAIL %s grant_id got %0d exp %0d", tag, grant_id, eid);
      end
    end
  endtask

  initial begin
    logic [1:0] rot_ids [5];
    rot_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    rst = 1'b1; req = 4'b0000; range_lo = 2'd0; range_hi = 2'd3; done = 1'b0;
    tick(); tick();
    check("reset", 4'b0000, 2'd0, 1'b0, 1'b1);
    rst = 1'b0;

    // basic grant, then release by done (ptr -> 3)
    req = 4'b0100;
    tick(); check("basic_grant", 4'b0100, 2'd2, 1'b1, 1'b1);
    done = 1'b1;
    tick(); check("basic_release", 4'b0000, 2'd0, 1'b0, 1'b0);
    done = 1'b0; req = 4'b0000;
    tick(); check("basic_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // reset restores ptr to 0, then rotate with done held high
    rst = 1'b1;
    tick(); check("reset2", 4'b0000, 2'd0, 1'b0, 1'b1);
    rst = 1'b0; req = 4'b1111; done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); check($sformatf("rot_grant%0d", i), 4'b0001 << rot_ids[i], rot_ids[i], 1'b1, 1'b1);
      tick(); check($sformatf("rot_gap%0d", i), 4'b0000, 2'd0, 1'b0, 1'b0);
    end
    req = 4'b0000; done = 1'b0;

    // window 1..2 filters out requesters 0 and 3 (ptr = 1)
    range_lo = 2'd1; range_hi = 2'd2; req = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      tick(); check("filter_none", 4'b0000, 2'd0, 1'b0, 1'b0);
    end
    req = 4'b1011;
    tick(); check("filter_grant1", 4'b0010, 2'd1, 1'b1, 1'b1);
    done = 1'b1;
    tick(); check("filter_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    done = 1'b0; req = 4'b0000;

    // window 1..3: grant 3 wraps ptr to range_lo, so 1 wins over 3
    range_lo = 2'd1; range_hi = 2'd3; req = 4'b1000;
    tick(); check("wrap_grant3", 4'b1000, 2'd3, 1'b1, 1'b1);
    done = 1'b1;
    tick(); check("wrap_rel3", 4'b0000, 2'd0, 1'b0, 1'b0);
    done = 1'b0; req = 4'b1010;
    tick(); check("wrap_grant1", 4'b0010, 2'd1, 1'b1, 1'b1);
    done = 1'b1;
    tick(); check("wrap_rel1", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick(); check("wrap_next3", 4'b1000, 2'd3, 1'b1, 1'b1);
    tick(); check("wrap_rel_b", 4'b0000, 2'd0, 1'b0, 1'b0);
    done = 1'b0; req = 4'b0000;

    // inverted window never grants (ptr = 1)
    range_lo = 2'd3; range_hi = 2'd1; req = 4'b1111;
    tick(); check("inv_none_a", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick(); check("inv_none_b", 4'b0000, 2'd0, 1'b0, 1'b0);

    // ptr = 1 outside window 2..3: search starts at range_lo
    range_lo = 2'd2; range_hi = 2'd3; req = 4'b1100;
    tick(); check("out_grant2", 4'b0100, 2'd2, 1'b1, 1'b1);
    done = 1'b1;
    tick(); check("out_rel2", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick(); check("out_grant3", 4'b1000, 2'd3, 1'b1, 1'b1);
    tick(); check("out_rel3", 4'b0000, 2'd0, 1'b0, 1'b0);
    done = 1'b0; req = 4'b0000;

    // hold while req stays high, window change ignored, release on req drop (ptr = 2)
    range_lo = 2'd0; range_hi = 2'd3; req = 4'b0100;
    tick(); check("drop_grant2", 4'b0100, 2'd2, 1'b1, 1'b1);
    range_lo = 2'd0; range_hi = 2'd0;
    tick(); check("drop_hold_a", 4'b0100, 2'd2, 1'b1, 1'b1);
    tick(); check("drop_hold_b", 4'b0100, 2'd2, 1'b1, 1'b1);
    req = 4'b0000;
    tick(); check("drop_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    range_lo = 2'd0; range_hi = 2'd3;

    // reset during BUSY clears grant and restarts at index 0 (ptr = 3)
    req = 4'b1111;
    tick(); check("rstmid_grant3", 4'b1000, 2'd3, 1'b1, 1'b1);
    rst = 1'b1;
    tick(); check("rstmid_clear", 4'b0000, 2'd0, 1'b0, 1'b1);
    rst = 1'b0;
    tick(); check("rstmid_grant0", 4'b0001, 2'd0, 1'b1, 1'b1);
    done = 1'b1;
    tick(); check("rstmid_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    done = 1'b0; req = 4'b0000;

`ifdef ARB_TIMEOUT_EN
    // ptr = 1 outside window 0..0; grant held exactly 4 cycles then forced off
    range_lo = 2'd0; range_hi = 2'd0; req = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tick(); check($sformatf("to_hold%0d", i), 4'b0001, 2'd0, 1'b1, 1'b1);
    end
    tick(); check("to_release", 4'b0000, 2'd0, 1'b0, 1'b0);
    tests++;
    assert (timeout_pulse === 1'b1) else begin
      fails++;
      $error("FAIL to_pulse got %b exp 1", timeout_pulse);
    end
    tick(); check("to_regrant", 4'b0001, 2'd0, 1'b1, 1'b1);
    tests++;
    assert (timeout_pulse === 1'b0) else begin
      fails++;
      $error("FAIL to_pulse_clear got %b exp 0", timeout_pulse);
    end
    req = 4'b0000; done = 1'b1;
    tick();
    done = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
